// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - shared widths, tag layout, states and init table for the AC97 command scheduler
package ac97_pkg;

    localparam int BITS_PER_FRAME = 256;
    localparam int TAG_W          = 16;
    localparam int SLOT_W         = 20;
    localparam int ADDR_W         = 7;
    localparam int DATA_W         = 16;
    localparam int ROM_IDX_W      = 2;

    // Slot0 tag bit positions (frame valid, then per-slot valid flags)
    localparam int TAG_FRAME_VALID = 15;
    localparam int TAG_SLOT1_VALID = 14;
    localparam int TAG_SLOT2_VALID = 13;
    localparam int TAG_SLOT3_VALID = 12;
    localparam int TAG_SLOT4_VALID = 11;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Init table entries packed as {addr, data}
    localparam int INIT_TABLE_LEN = 3;
    localparam logic [ADDR_W+DATA_W-1:0] INIT_MASTER_VOL  = {7'h02, 16'h0000};
    localparam logic [ADDR_W+DATA_W-1:0] INIT_PCM_OUT_VOL = {7'h18, 16'h0808};
    localparam logic [ADDR_W+DATA_W-1:0] INIT_HP_VOL      = {7'h04, 16'h0000};

    // Tag word: frame valid always set, command slots follow cv, PCM slots follow pv
    function automatic logic [TAG_W-1:0] make_tag(input logic cv, input logic pv);
        logic [TAG_W-1:0] tag;
        tag                  = '0;
        tag[TAG_FRAME_VALID] = 1'b1;
        tag[TAG_SLOT1_VALID] = cv;
        tag[TAG_SLOT2_VALID] = cv;
        tag[TAG_SLOT3_VALID] = pv;
        tag[TAG_SLOT4_VALID] = pv;
        return tag;
    endfunction

    // Command address slot: write flag (0), register address, reserved low bits
    function automatic logic [SLOT_W-1:0] make_slot1(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr, 12'd0};
    endfunction

    // Command data slot: register data left-justified
    function automatic logic [SLOT_W-1:0] make_slot2(input logic [DATA_W-1:0] data);
        return {data, 4'd0};
    endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// rtl/ac97_init_rom.sv - combinational lookup of the codec init register-write table
module ac97_init_rom
    import ac97_pkg::*;
(
    input  logic [1:0]  i_idx,
    output logic [6:0]  o_addr,
    output logic [15:0] o_data
);

    logic [ADDR_W+DATA_W-1:0] w_entry;

    // Table lookup; out-of-range indices read as an all-zero entry
    always_comb begin
        w_entry = '0;
        case (i_idx)
            2'd0:    w_entry = INIT_MASTER_VOL;
            2'd1:    w_entry = INIT_PCM_OUT_VOL;
            2'd2:    w_entry = INIT_HP_VOL;
            default: w_entry = '0;
        endcase
    end

    assign o_addr = w_entry[ADDR_W+DATA_W-1:DATA_W];
    assign o_data = w_entry[DATA_W-1:0];

endmodule

// File: rtl/ac97_cmd_scheduler.sv
// rtl/ac97_cmd_scheduler.sv - codec power-up wait, init table playback and runtime write arbitration
module ac97_cmd_scheduler
    import ac97_pkg::*;
#(
    parameter int WAIT_FRAMES = 507,
    parameter int INIT_LEN    = INIT_TABLE_LEN,
    parameter int GAP_FRAMES  = 1
) (
    input  logic        BIT_CLK,
    input  logic        reset,
    input  logic [7:0]  bitCount,
    input  logic        req0,
    input  logic [6:0]  addr0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [6:0]  addr1,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] slot0,
    output logic [19:0] slot1,
    output logic [19:0] slot2,
    output logic        init_done
);

    state_t              r_state;
    logic [9:0]          r_frame_cnt;
    logic [3:0]          r_gap;
    logic [1:0]          r_idx;
    logic                r_rr;
    logic                r_init_done;
    logic                r_ack0;
    logic                r_ack1;
    logic [TAG_W-1:0]    r_slot0;
    logic [SLOT_W-1:0]   r_slot1;
    logic [SLOT_W-1:0]   r_slot2;

    state_t              w_state_nx;
    logic [9:0]          w_cnt_nx;
    logic [3:0]          w_gap_nx;
    logic [1:0]          w_idx_nx;
    logic                w_rr_nx;
    logic                w_done_nx;
    logic                w_cv;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_fb;
    logic [ADDR_W-1:0]   w_rom_addr;
    logic [DATA_W-1:0]   w_rom_data;

    assign w_fb = (bitCount == 8'(BITS_PER_FRAME - 1));

    ac97_init_rom u_init_rom (
        .i_idx  (r_idx),
        .o_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    // Next-state and command selection, evaluated every cycle but committed only at a frame boundary
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_frame_cnt;
        w_gap_nx   = r_gap;
        w_idx_nx   = r_idx;
        w_rr_nx    = r_rr;
        w_done_nx  = r_init_done;
        w_cv       = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;

        case (r_state)
            ST_WAIT: begin
                if (r_frame_cnt != 10'h3FF) begin
                    w_cnt_nx = r_frame_cnt + 10'd1;
                end
                if (w_cnt_nx == 10'(WAIT_FRAMES)) begin
                    w_cv       = 1'b1;
                    w_addr     = w_rom_addr;
                    w_data     = w_rom_data;
                    w_idx_nx   = r_idx + 2'd1;
                    w_gap_nx   = 4'(GAP_FRAMES);
                    w_state_nx = ST_INIT;
                end
            end

            ST_INIT: begin
                if (r_gap != 4'd0) begin
                    w_gap_nx = r_gap - 4'd1;
                end else if (r_idx == ROM_IDX_W'(INIT_LEN)) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = ST_RUN;
                end else begin
                    w_cv     = 1'b1;
                    w_addr   = w_rom_addr;
                    w_data   = w_rom_data;
                    w_idx_nx = r_idx + 2'd1;
                    w_gap_nx = 4'(GAP_FRAMES);
                end
            end

            ST_RUN: begin
                if (r_gap != 4'd0) begin
                    w_gap_nx = r_gap - 4'd1;
                end else begin
                    if (req0 && req1) begin
                        w_grant0 = r_rr;
                        w_grant1 = !r_rr;
                        w_rr_nx  = !r_rr;
                    end else begin
                        w_grant0 = req0;
                        w_grant1 = req1;
                    end
                    if (w_grant0) begin
                        w_cv   = 1'b1;
                        w_addr = addr0;
                        w_data = data0;
                    end else if (w_grant1) begin
                        w_cv   = 1'b1;
                        w_addr = addr1;
                        w_data = data1;
                    end
                    if (w_cv) begin
                        w_gap_nx = 4'(GAP_FRAMES);
                    end
                end
            end

            default: begin
                w_state_nx = ST_WAIT;
            end
        endcase
    end

    // State and slot registers; acks pulse on the boundary edge and clear on the next one
    always_ff @(posedge BIT_CLK) begin
        if (!reset) begin
            r_state     <= ST_WAIT;
            r_frame_cnt <= '0;
            r_gap       <= '0;
            r_idx       <= '0;
            r_rr        <= 1'b0;
            r_init_done <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_slot2     <= '0;
        end else begin
            r_ack0 <= w_fb && w_grant0;
            r_ack1 <= w_fb && w_grant1;
            if (w_fb) begin
                r_state     <= w_state_nx;
                r_frame_cnt <= w_cnt_nx;
                r_gap       <= w_gap_nx;
                r_idx       <= w_idx_nx;
                r_rr        <= w_rr_nx;
                r_init_done <= w_done_nx;
                r_slot0     <= make_tag(w_cv, w_done_nx);
                r_slot1     <= w_cv ? make_slot1(w_addr) : '0;
                r_slot2     <= w_cv ? make_slot2(w_data) : '0;
            end
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign slot0     = r_slot0;
    assign slot1     = r_slot1;
    assign slot2     = r_slot2;
    assign init_done = r_init_done;

endmodule
